// File: rtl/subcarrier_alloc.sv
// subcarrier_alloc: gathers the 8 mapped words of an OFDM symbol into a 64-bin IFFT frame and streams it out.
// Ping-pong buffered. Define SCA_BITREV_EN to emit the bins in bit-reversed (radix-2 DIT) order.

// Per-lane map: data index d = 6*wc + LANE -> IFFT bin of that data subcarrier.
module sca_lane_map #(
  parameter int LANE = 0
) (
  input  logic [2:0] wc,
  output logic [5:0] bin
);
  logic [5:0] d;

  always_comb begin
    d = 6'(wc) * 6'd6 + 6'(LANE);
    // Segments of the data subcarrier list, skipping DC, pilots and guards.
    if      (d < 6'd5)  bin = d + 6'd38;
    else if (d < 6'd18) bin = d + 6'd39;
    else if (d < 6'd24) bin = d + 6'd40;
    else if (d < 6'd30) bin = d - 6'd23;
    else if (d < 6'd43) bin = d - 6'd22;
    else                bin = d - 6'd21;
  end
endmodule

module subcarrier_alloc #(
  parameter int DW    = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [51:0]      in_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [DW-1:0]    out_data,
  output logic [5:0]       out_bin,
  output logic             out_sop,
  output logic             out_eop,
  output logic             overflow,
  output logic [CNT_W-1:0] sym_cnt
);
  localparam int LANES = 6;

  typedef enum logic {IDLE, RUN} state_t;

  logic [DW-1:0]           mem [2][64];
  logic [LANES-1:0][5:0]   lane_bin;
  logic [5:0]              pil_bin;
  logic [2:0]              wc;
  logic                    wbank, drop;
  logic [1:0]              full;
  logic                    start, tgt_busy, accept, done;

  state_t                  state, state_nx;
  logic                    rbank;
  logic [5:0]              n;
  logic                    hs, last, free;
  logic                    ld, ld_bank;
  logic [5:0]              ld_n, ld_bin;
  logic                    zero_bin;
  logic [DW-1:0]           rd;

  // ---------------- write side ----------------
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    sca_lane_map #(.LANE(j)) u_map (.wc(wc), .bin(lane_bin[j]));
  end

  always_comb begin
    case (wc[2:1])
      2'd0:    pil_bin = 6'd43;
      2'd1:    pil_bin = 6'd57;
      2'd2:    pil_bin = 6'd7;
      default: pil_bin = 6'd21;
    endcase
  end

  // A bank draining its last sample this cycle counts as free for a new symbol.
  assign start    = in_valid && (wc == 3'd0);
  assign tgt_busy = full[wbank] && !(free && (rbank == wbank));
  assign accept   = in_valid && !drop && !(start && tgt_busy);
  assign done     = accept && (wc == 3'd7);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wc       <= 3'd0;
      wbank    <= 1'b0;
      drop     <= 1'b0;
      overflow <= 1'b0;
    end else if (in_valid) begin
      wc <= wc + 3'd1;
      if (start && tgt_busy) begin
        drop     <= 1'b1;
        overflow <= 1'b1;
      end else if (wc == 3'd7) begin
        drop <= 1'b0;
      end
      if (done) wbank <= ~wbank;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 2'b00;
    end else begin
      if (free) full[rbank] <= 1'b0;
      if (done) full[wbank] <= 1'b1;
    end
  end

  // Guard and DC bins are never written; the read path forces them to zero.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int j = 0; j < LANES; j++)
        mem[wbank][lane_bin[j]] <= DW'(in_data[8*j +: 8]);
      if (!wc[0]) mem[wbank][pil_bin] <= DW'({in_data[51:48], 4'd0});
    end
  end

  // ---------------- read side ----------------
  assign hs   = (state == RUN) && out_ready;
  assign last = (n == 6'd63);
  assign free = hs && last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (full[rbank]) state_nx = RUN;
      RUN:  if (free && !full[~rbank]) state_nx = IDLE;
    endcase
  end

  always_comb begin
    ld      = 1'b0;
    ld_bank = rbank;
    ld_n    = 6'd0;
    case (state)
      IDLE: ld = full[rbank];
      RUN: if (hs) begin
        ld      = !last || full[~rbank];
        ld_n    = last ? 6'd0 : n + 6'd1;
        ld_bank = last ? ~rbank : rbank;
      end
    endcase
  end

`ifdef SCA_BITREV_EN
  assign ld_bin = {ld_n[0], ld_n[1], ld_n[2], ld_n[3], ld_n[4], ld_n[5]};
`else
  assign ld_bin = ld_n;
`endif

  assign zero_bin = (ld_bin == 6'd0) || ((ld_bin >= 6'd27) && (ld_bin <= 6'd37));
  assign rd       = zero_bin ? '0 : mem[ld_bank][ld_bin];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rbank    <= 1'b0;
      n        <= 6'd0;
      out_data <= '0;
      out_bin  <= 6'd0;
      out_sop  <= 1'b0;
      out_eop  <= 1'b0;
      sym_cnt  <= '0;
    end else begin
      if (free) begin
        rbank   <= ~rbank;
        sym_cnt <= sym_cnt + CNT_W'(1);
      end
      if (ld) begin
        n        <= ld_n;
        out_data <= rd;
        out_bin  <= ld_bin;
        out_sop  <= (ld_n == 6'd0);
        out_eop  <= (ld_n == 6'd63);
      end else if (free) begin
        out_sop <= 1'b0;
        out_eop <= 1'b0;
      end
    end
  end

  assign out_valid = (state == RUN);

endmodule
